gpu_cmd_slave: RTL and testbench
================================

GPU_CMD_SLAVE -- requirements
Module: gpu_cmd_slave

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of queued render operations (power of 2, minimum 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have ports PSEL in 1, PWRITE in 1, PWDATA in 32, PRDATA out 32, forming the host command/status port.
REQ-005 SHALL have port op_valid, output, 1 bit: head render operation is available.
REQ-006 SHALL have port op_ready, input, 1 bit: renderer accepts the head operation.
REQ-007 SHALL have output ports op_code (2 bits; 00 clear, 01 draw, 10 flip), op_x0 (9), op_y0 (8), op_x1 (9), op_y1 (8) and op_color (24), carrying the head operation snapshot.

Function
REQ-008 SHALL detect a transaction at a rising edge where PSEL=1 and the registered previous PSEL=0; at most one transaction per PSEL assertion.
REQ-009 SHALL decode a write transaction as PWDATA[31:27]=reserved, [26:24]=opcode, [23:0]=data; coordinate data uses x=data[16:8] and y=data[7:0].
REQ-010 SHALL treat a write with nonzero PWDATA[31:27] as a format error: set sticky fmt_err, no other effect.
REQ-011 SHALL execute opcodes as follows: 001 set start; 010 set end; 011 color=data; 100 start += (x,y); 101 end += (x,y); 000 enqueue clear; 110 enqueue draw; 111 enqueue flip.
REQ-012 SHALL saturate move results at x=319 and y=239.
REQ-013 SHALL make register updates visible in the cycle after the detecting edge.
REQ-014 SHALL snapshot start, end and color into the FIFO entry at the detecting edge of an enqueue command.
REQ-015 SHALL provide first-word-fall-through output: with the FIFO empty, op_valid rises in the cycle after the enqueue edge.
REQ-016 SHALL pop the head entry at an edge with op_valid=1 and op_ready=1.
REQ-017 SHALL keep op_* outputs stable while op_valid=1 and op_ready=0.
REQ-018 SHALL, on an enqueue while full, drop the command and set sticky ovf; a simultaneous pop and push while full SHALL succeed with no ovf.
REQ-019 SHALL, on a read transaction (PWRITE=0), register PRDATA = {24'b0, rng_err, fmt_err, ovf, empty, full, count[2:0]}, valid from the cycle after the detecting edge and held until the next read.
REQ-020 SHALL clear the sticky flags on a read after capturing them; a flag-setting event at the same edge wins (flag remains set).

Reset
REQ-021 SHALL, while rst=1 at an edge, clear the FIFO, all coordinates, color (24'h000000), sticky flags and PRDATA, and drive op_valid=0 from the next cycle.
REQ-022 SHALL reset the previous-PSEL register to 1, so PSEL held high through reset is not a transaction.
REQ-023 SHALL discard an operation presented but not yet accepted when reset occurs.

Configuration
REQ-024 SHALL, with GPU_CMD_RANGE_CHECK_EN defined, reject set start/end writes with x>319 or y>239, leaving the registers unchanged and setting sticky rng_err.
REQ-025 SHALL, without GPU_CMD_RANGE_CHECK_EN, load set start/end data unchecked, with rng_err reading 0.

Structure
REQ-026 SHALL take opcode enum, op_code enum, screen limits (320/240) and the FIFO entry struct from shared package gpu_pkg.
REQ-027 SHALL implement queueing in one sub-module gpu_op_fifo, parameterized by depth and entry type.

Verification
REQ-028 SHALL verify: set start (0,0), set end (319,239), color 00FF00, draw, op_ready=1 -> one op: code 01, (0,0)-(319,239), color 00FF00.
REQ-029 SHALL verify: start (318,0), move start (1,0) twice, draw -> op_x0=319 (saturated).
REQ-030 SHALL verify: op_ready=0, five draws with FIFO_DEPTH=4 -> status count=4, full=1, ovf=1; a second read shows ovf=0.
REQ-031 SHALL verify: PSEL held 6 cycles with a draw -> exactly one entry queued.
REQ-032 SHALL verify: PWDATA=32'h0800_0000 -> fmt_err=1, no queue change; with the macro defined, set start x=320 -> rng_err=1, start unchanged.
REQ-033 SHALL verify: rst asserted with 3 entries queued and PSEL high -> op_valid=0 and PRDATA=0 after reset, and no spurious transaction.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared types, screen limits and saturating coordinate helpers for the GPU command slave.
package gpu_pkg;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    localparam int X_MAX    = SCREEN_W - 1;
    localparam int Y_MAX    = SCREEN_H - 1;

    typedef enum logic [2:0] {
        CMD_CLEAR      = 3'b000,
        CMD_SET_START  = 3'b001,
        CMD_SET_END    = 3'b010,
        CMD_SET_COLOR  = 3'b011,
        CMD_MOVE_START = 3'b100,
        CMD_MOVE_END   = 3'b101,
        CMD_DRAW       = 3'b110,
        CMD_FLIP       = 3'b111
    } cmd_op_t;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'b00,
        OP_DRAW  = 2'b01,
        OP_FLIP  = 2'b10
    } op_code_t;

    typedef struct packed {
        op_code_t    code;
        logic [8:0]  x0;
        logic [7:0]  y0;
        logic [8:0]  x1;
        logic [7:0]  y1;
        logic [23:0] color;
    } op_entry_t;

    // Moves clamp at the last visible pixel; an out-of-range base also clamps.
    function automatic logic [8:0] sat_add_x(input logic [8:0] a, input logic [8:0] b);
        logic [9:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > 10'(X_MAX)) ? 9'(X_MAX) : sum[8:0];
    endfunction

    function automatic logic [7:0] sat_add_y(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > 9'(Y_MAX)) ? 8'(Y_MAX) : sum[7:0];
    endfunction

endpackage

// File: rtl/gpu_op_fifo.sv
// First-word-fall-through queue of render operations; a push while full is
// accepted only when the head is popped at the same edge, otherwise dropped.
module gpu_op_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = logic [7:0],
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  entry_t           push_data,
    input  logic             pop_ready,
    output logic             out_valid,
    output entry_t           head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             drop
);

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_pop;
    logic               do_push;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign out_valid = !empty;
    assign head      = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign do_pop    = out_valid && pop_ready;
    assign do_push   = push && (!full || do_pop);
    assign drop      = push && full && !do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/gpu_cmd_slave.sv
// Host command slave: decodes register writes into a render-op queue and reports status on reads.
// Define GPU_CMD_RANGE_CHECK_EN to reject off-screen set start/end coordinates (sets rng_err).
module gpu_cmd_slave
    import gpu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PSEL,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [1:0]  op_code,
    output logic [8:0]  op_x0,
    output logic [7:0]  op_y0,
    output logic [8:0]  op_x1,
    output logic [7:0]  op_y1,
    output logic [23:0] op_color
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic              psel_prev_q, psel_prev_d;
    logic [8:0]        x0_q, x0_d, x1_q, x1_d;
    logic [7:0]        y0_q, y0_d, y1_q, y1_d;
    logic [23:0]       color_q, color_d;
    logic              fmt_err_q, fmt_err_d;
    logic              ovf_q, ovf_d;
    logic              rng_err_q, rng_err_d;
    logic [31:0]       prdata_q, prdata_d;

    logic              txn, wr_txn, rd_txn;
    cmd_op_t           cmd;
    logic [23:0]       data;
    logic [8:0]        arg_x;
    logic [7:0]        arg_y;
    logic              range_bad;
    logic              fmt_set, rng_set;
    logic              push;
    op_entry_t         push_entry;
    op_entry_t         head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full, fifo_empty, fifo_drop;

    // One transaction per PSEL assertion: only the rising edge of PSEL counts.
    assign txn    = PSEL && !psel_prev_q;
    assign wr_txn = txn && PWRITE;
    assign rd_txn = txn && !PWRITE;
    assign cmd    = cmd_op_t'(PWDATA[26:24]);
    assign data   = PWDATA[23:0];
    assign arg_x  = data[16:8];
    assign arg_y  = data[7:0];

`ifdef GPU_CMD_RANGE_CHECK_EN
    assign range_bad = (arg_x > 9'(X_MAX)) || (arg_y > 8'(Y_MAX));
`else
    assign range_bad = 1'b0;
`endif

    always_comb begin
        psel_prev_d = PSEL;
        x0_d        = x0_q;
        y0_d        = y0_q;
        x1_d        = x1_q;
        y1_d        = y1_q;
        color_d     = color_q;
        fmt_set     = 1'b0;
        rng_set     = 1'b0;
        push        = 1'b0;
        push_entry  = '{code: OP_DRAW, x0: x0_q, y0: y0_q, x1: x1_q, y1: y1_q, color: color_q};
        if (wr_txn) begin
            if (PWDATA[31:27] != '0) begin
                fmt_set = 1'b1;
            end else begin
                case (cmd)
                    CMD_SET_START: begin
                        if (range_bad) rng_set = 1'b1;
                        else begin
                            x0_d = arg_x;
                            y0_d = arg_y;
                        end
                    end
                    CMD_SET_END: begin
                        if (range_bad) rng_set = 1'b1;
                        else begin
                            x1_d = arg_x;
                            y1_d = arg_y;
                        end
                    end
                    CMD_SET_COLOR:  color_d = data;
                    CMD_MOVE_START: begin
                        x0_d = sat_add_x(x0_q, arg_x);
                        y0_d = sat_add_y(y0_q, arg_y);
                    end
                    CMD_MOVE_END: begin
                        x1_d = sat_add_x(x1_q, arg_x);
                        y1_d = sat_add_y(y1_q, arg_y);
                    end
                    CMD_CLEAR: begin
                        push            = 1'b1;
                        push_entry.code = OP_CLEAR;
                    end
                    CMD_DRAW: begin
                        push            = 1'b1;
                        push_entry.code = OP_DRAW;
                    end
                    CMD_FLIP: begin
                        push            = 1'b1;
                        push_entry.code = OP_FLIP;
                    end
                endcase
            end
        end
    end

    // Status captures pre-edge flags; a set at the clearing edge still wins.
    always_comb begin
        fmt_err_d = (fmt_err_q && !rd_txn) || fmt_set;
        ovf_d     = (ovf_q && !rd_txn) || fifo_drop;
        rng_err_d = (rng_err_q && !rd_txn) || rng_set;
        prdata_d  = prdata_q;
        if (rd_txn) begin
            prdata_d = {24'b0, rng_err_q, fmt_err_q, ovf_q, fifo_empty, fifo_full, 3'(fifo_count)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            psel_prev_q <= 1'b1;
            x0_q        <= '0;
            y0_q        <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            color_q     <= '0;
            fmt_err_q   <= 1'b0;
            ovf_q       <= 1'b0;
            rng_err_q   <= 1'b0;
            prdata_q    <= '0;
        end else begin
            psel_prev_q <= psel_prev_d;
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            x1_q        <= x1_d;
            y1_q        <= y1_d;
            color_q     <= color_d;
            fmt_err_q   <= fmt_err_d;
            ovf_q       <= ovf_d;
            rng_err_q   <= rng_err_d;
            prdata_q    <= prdata_d;
        end
    end

    gpu_op_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (op_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop_ready (op_ready),
        .out_valid (op_valid),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .drop      (fifo_drop)
    );

    assign PRDATA   = prdata_q;
    assign op_code  = head.code;
    assign op_x0    = head.x0;
    assign op_y0    = head.y0;
    assign op_x1    = head.x1;
    assign op_y1    = head.y1;
    assign op_color = head.color;

endmodule

// File: tb/tb_gpu_cmd_slave.sv
// Directed self-checking bench for gpu_cmd_slave (FIFO_DEPTH = 4).
module tb_gpu_cmd_slave;

    logic        clk;
    logic        rst;
    logic        PSEL;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        op_valid;
    logic        op_ready;
    logic [1:0]  op_code;
    logic [8:0]  op_x0;
    logic [7:0]  op_y0;
    logic [8:0]  op_x1;
    logic [7:0]  op_y1;
    logic [23:0] op_color;

    int checkCount;
    int passCount;

    localparam logic [31:0] W_DRAW  = 32'h0600_0000;
    localparam logic [31:0] W_CLEAR = 32'h0000_0000;
    localparam logic [31:0] W_FLIP  = 32'h0700_0000;

    gpu_cmd_slave #(.FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .PSEL     (PSEL),
        .PWRITE   (PWRITE),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_code  (op_code),
        .op_x0    (op_x0),
        .op_y0    (op_y0),
        .op_x1    (op_x1),
        .op_y1    (op_y1),
        .op_color (op_color)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    endtask

    // One PSEL assertion held for holdCycles edges, then one idle cycle.
    task automatic applyStimulus(input logic write, input logic [31:0] wdata, input int holdCycles);
        @(negedge clk);
        PSEL   = 1'b1;
        PWRITE = write;
        PWDATA = wdata;
        repeat (holdCycles) @(negedge clk);
        PSEL   = 1'b0;
        @(negedge clk);
    endtask

    task automatic checkStatus(input string tag, input logic [31:0] expected);
        applyStimulus(1'b0, 32'h0, 1);
        checkOutput(tag, PRDATA, expected);
    endtask

    task automatic popOne();
        op_ready = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;
    endtask

    initial begin
        logic [1:0] drainCodes [4];
        checkCount = 0;
        passCount  = 0;
        rst        = 1'b1;
        PSEL       = 1'b0;
        PWRITE     = 1'b0;
        PWDATA     = 32'h0;
        op_ready   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset op_valid", {31'b0, op_valid}, 32'h0);
        checkOutput("reset PRDATA", PRDATA, 32'h0);
        checkStatus("reset status", 32'h0000_0010);

        // Basic draw with full-screen diagonal
        applyStimulus(1'b1, 32'h0100_0000, 1);
        applyStimulus(1'b1, 32'h0201_3FEF, 1);
        applyStimulus(1'b1, 32'h0300_FF00, 1);
        applyStimulus(1'b1, W_DRAW, 1);
        checkOutput("draw valid", {31'b0, op_valid}, 32'h1);
        checkOutput("draw code", {30'b0, op_code}, 32'h1);
        checkOutput("draw x0", {23'b0, op_x0}, 32'd0);
        checkOutput("draw y0", {24'b0, op_y0}, 32'd0);
        checkOutput("draw x1", {23'b0, op_x1}, 32'd319);
        checkOutput("draw y1", {24'b0, op_y1}, 32'd239);
        checkOutput("draw color", {8'b0, op_color}, 32'h0000_FF00);
        @(negedge clk);
        checkOutput("hold x1 stable", {23'b0, op_x1}, 32'd319);
        popOne();
        checkOutput("popped valid", {31'b0, op_valid}, 32'h0);
        checkStatus("after pop status", 32'h0000_0010);

        // Saturating moves
        applyStimulus(1'b1, 32'h0101_3E00, 1);
        applyStimulus(1'b1, 32'h0400_0100, 1);
        applyStimulus(1'b1, 32'h0400_0100, 1);
        applyStimulus(1'b1, 32'h0200_00E6, 1);
        applyStimulus(1'b1, 32'h0500_0014, 1);
        applyStimulus(1'b1, 32'h0500_0302, 1);
        applyStimulus(1'b1, W_DRAW, 1);
        checkOutput("sat x0", {23'b0, op_x0}, 32'd319);
        checkOutput("sat y0", {24'b0, op_y0}, 32'd0);
        checkOutput("move x1", {23'b0, op_x1}, 32'd3);
        checkOutput("sat y1", {24'b0, op_y1}, 32'd239);
        popOne();

        // Overflow, sticky clear, pop+push while full, ordering
        applyStimulus(1'b1, W_CLEAR, 1);
        applyStimulus(1'b1, W_DRAW, 1);
        applyStimulus(1'b1, W_FLIP, 1);
        applyStimulus(1'b1, W_DRAW, 1);
        applyStimulus(1'b1, W_FLIP, 1);
        checkStatus("ovf status", 32'h0000_002C);
        checkStatus("ovf cleared", 32'h0000_000C);
        checkOutput("full head code", {30'b0, op_code}, 32'h0);
        @(negedge clk);
        op_ready = 1'b1;
        PSEL     = 1'b1;
        PWRITE   = 1'b1;
        PWDATA   = W_CLEAR;
        @(negedge clk);
        op_ready = 1'b0;
        PSEL     = 1'b0;
        @(negedge clk);
        checkStatus("pop+push full", 32'h0000_000C);
        drainCodes[0] = 2'b01;
        drainCodes[1] = 2'b10;
        drainCodes[2] = 2'b01;
        drainCodes[3] = 2'b00;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("drain code %0d", i), {30'b0, op_code}, {30'b0, drainCodes[i]});
            popOne();
        end
        checkOutput("drained valid", {31'b0, op_valid}, 32'h0);

        // PSEL held high counts once
        applyStimulus(1'b1, W_DRAW, 6);
        checkStatus("held psel count", 32'h0000_0001);
        popOne();

        // Format error, then range behaviour
        applyStimulus(1'b1, 32'h0800_0000, 1);
        checkStatus("fmt_err status", 32'h0000_0050);
        checkStatus("fmt_err cleared", 32'h0000_0010);
        applyStimulus(1'b1, 32'h0100_0506, 1);
        applyStimulus(1'b1, 32'h0101_4000, 1);
`ifdef GPU_CMD_RANGE_CHECK_EN
        checkStatus("rng_err status", 32'h0000_0090);
        applyStimulus(1'b1, W_DRAW, 1);
        checkOutput("rng start x", {23'b0, op_x0}, 32'd5);
        checkOutput("rng start y", {24'b0, op_y0}, 32'd6);
`else
        checkStatus("rng_err status", 32'h0000_0010);
        applyStimulus(1'b1, W_DRAW, 1);
        checkOutput("rng start x", {23'b0, op_x0}, 32'd320);
        checkOutput("rng start y", {24'b0, op_y0}, 32'd0);
`endif
        popOne();

        // Reset with entries queued and PSEL high
        applyStimulus(1'b1, W_DRAW, 1);
        applyStimulus(1'b1, W_FLIP, 1);
        applyStimulus(1'b1, W_DRAW, 1);
        checkStatus("pre-reset count", 32'h0000_0003);
        @(negedge clk);
        PSEL   = 1'b1;
        PWRITE = 1'b1;
        PWDATA = W_DRAW;
        rst    = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("post-reset valid", {31'b0, op_valid}, 32'h0);
        checkOutput("post-reset PRDATA", PRDATA, 32'h0);
        PSEL = 1'b0;
        @(negedge clk);
        checkStatus("post-reset status", 32'h0000_0010);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
